// File: rtl/icache.sv
// Direct-mapped 16-bit-parcel instruction cache: combinational hits, single 4-byte fill per miss.
// Latency: hit 0 cycles; miss forwards the word in the mem_ready cycle. Backpressure: rdy=0 freezes everything.
module icache #(
  parameter int INDEX_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        flush,
  input  logic [31:0] fet_pc,
  input  logic        mem_ready,
  input  logic [31:0] mem_inst,
  output logic        icache_ready,
  output logic [31:0] icache_inst,
  output logic        icache_mem_req,
  output logic [31:0] icache_mem_addr
);
  localparam int N  = 2 ** INDEX_BITS;
  localparam int TW = 31 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_DISCARD} state_t;

  state_t r_state, w_next;
  logic [31:0] r_addr;
  logic [N-1:0] r_vld;
  logic [TW-1:0] r_tag [N];
  logic [15:0] r_dat [N];

  // Halfword addresses: index is the low bits, tag the rest, so p1 wraps naturally
  logic [30:0] w_hw0, w_hw1, w_fhw0, w_fhw1;
  logic [INDEX_BITS-1:0] w_idx0, w_idx1, w_fidx0, w_fidx1;
  logic w_hit0, w_hit1, w_comp, w_hit, w_fill;
  logic [31:0] w_lookup;

  assign w_hw0   = fet_pc[31:1];
  assign w_hw1   = fet_pc[31:1] + 31'd1;
  assign w_fhw0  = r_addr[31:1];
  assign w_fhw1  = r_addr[31:1] + 31'd1;
  assign w_idx0  = w_hw0[INDEX_BITS-1:0];
  assign w_idx1  = w_hw1[INDEX_BITS-1:0];
  assign w_fidx0 = w_fhw0[INDEX_BITS-1:0];
  assign w_fidx1 = w_fhw1[INDEX_BITS-1:0];

  assign w_hit0   = r_vld[w_idx0] && (r_tag[w_idx0] == w_hw0[30:INDEX_BITS]);
  assign w_hit1   = r_vld[w_idx1] && (r_tag[w_idx1] == w_hw1[30:INDEX_BITS]);
  assign w_comp   = (r_dat[w_idx0][1:0] != 2'b11);
  assign w_hit    = w_hit0 && (w_comp || w_hit1);
  assign w_lookup = w_comp ? {16'b0, r_dat[w_idx0]} : {r_dat[w_idx1], r_dat[w_idx0]};

  // A returned word is always written, even after a flush, since it is correct for its address
  assign w_fill = rdy && mem_ready && (r_state != S_IDLE);

  assign icache_mem_addr = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (rdy) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (!flush && !w_hit) w_next = S_MISS;
      S_MISS: begin
        if (mem_ready) w_next = S_IDLE;
        else if (flush) w_next = S_DISCARD;
      end
      S_DISCARD: if (mem_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    icache_ready   = 1'b0;
    icache_inst    = 32'b0;
    icache_mem_req = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          icache_inst  = w_lookup;
          icache_ready = rdy && !flush;
        end
      end
      S_MISS: begin
        if (rdy && mem_ready) begin
          icache_inst  = (mem_inst[1:0] != 2'b11) ? {16'b0, mem_inst[15:0]} : mem_inst;
          icache_ready = !flush;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= 32'b0;
    end else if (rdy && !flush && !w_hit && (r_state == S_IDLE)) begin
      r_addr <= fet_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_fill) begin
      r_vld[w_fidx0] <= 1'b1;
      r_vld[w_fidx1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fidx0] <= w_fhw0[30:INDEX_BITS];
      r_dat[w_fidx0] <= mem_inst[15:0];
      r_tag[w_fidx1] <= w_fhw1[30:INDEX_BITS];
      r_dat[w_fidx1] <= mem_inst[31:16];
    end
  end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios then random fetches against a parcel-address reference model.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        flush;
  logic [31:0] fet_pc;
  logic        mem_ready;
  logic [31:0] mem_inst;
  logic        icache_ready;
  logic [31:0] icache_inst;
  logic        icache_mem_req;
  logic [31:0] icache_mem_addr;

  int checks = 0;
  int failures = 0;

  // Model: each of 256 slots remembers which full parcel address it holds
  bit          mv [256];
  logic [31:0] ma [256];
  logic [15:0] md [256];

  icache #(.INDEX_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .fet_pc(fet_pc),
    .mem_ready(mem_ready), .mem_inst(mem_inst), .icache_ready(icache_ready),
    .icache_inst(icache_inst), .icache_mem_req(icache_mem_req),
    .icache_mem_addr(icache_mem_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int slot(input logic [31:0] a);
    return int'((a / 2) % 256);
  endfunction

  function automatic bit present(input logic [31:0] a);
    return mv[slot(a)] && (ma[slot(a)] == a);
  endfunction

  function automatic logic [31:0] fmt(input logic [31:0] w);
    return (w[1:0] != 2'b11) ? {16'b0, w[15:0]} : w;
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] t;
    t = (a + 32'h1357) * 32'h9E3779B1;
    return t[31:16];
  endfunction

  task automatic model_lookup(input logic [31:0] pc, output logic hit, output logic [31:0] inst);
    logic [15:0] d0, d1;
    d0 = md[slot(pc)];
    d1 = md[slot(pc + 32'd2)];
    if (d0[1:0] != 2'b11) begin
      hit  = present(pc);
      inst = {16'b0, d0};
    end else begin
      hit  = present(pc) && present(pc + 32'd2);
      inst = {d1, d0};
    end
  endtask

  task automatic model_fill(input logic [31:0] a, input logic [31:0] w);
    mv[slot(a)] = 1'b1;          ma[slot(a)] = a;          md[slot(a)] = w[15:0];
    mv[slot(a + 32'd2)] = 1'b1;  ma[slot(a + 32'd2)] = a + 32'd2;  md[slot(a + 32'd2)] = w[31:16];
  endtask

  // Look up pc; on a miss let memory answer after dly cycles, with flush pulsed at cycle fl_at (-1: never)
  task automatic fetch(input logic [31:0] pc, input logic [31:0] w, input int dly, input int fl_at);
    logic eh, fl;
    logic [31:0] ei;
    model_lookup(pc, eh, ei);
    fet_pc = pc; rdy = 1'b1; flush = 1'b0; mem_ready = 1'b0; #1;
    chk("req_idle", {31'b0, icache_mem_req}, 32'd0);
    chk("hit", {31'b0, icache_ready}, {31'b0, eh});
    if (eh) chk("hit_inst", icache_inst, ei);
    @(posedge clk); #1;
    if (!eh) begin
      fl = 1'b0;
      for (int c = 0; c < dly; c++) begin
        flush = (c == fl_at); mem_ready = 1'b0; #1;
        chk("miss_req", {31'b0, icache_mem_req}, 32'd1);
        chk("miss_addr", icache_mem_addr, pc);
        chk("miss_rdy", {31'b0, icache_ready}, 32'd0);
        if (c == fl_at) fl = 1'b1;
        @(posedge clk); #1;
      end
      flush = (fl_at == dly); mem_ready = 1'b1; mem_inst = w; #1;
      chk("fill_req", {31'b0, icache_mem_req}, 32'd1);
      chk("fill_rdy", {31'b0, icache_ready}, {31'b0, !(fl || flush)});
      if (!(fl || flush)) chk("fill_inst", icache_inst, fmt(w));
      @(posedge clk);
      model_fill(pc, w);
      #1 mem_ready = 1'b0; flush = 1'b0; #1;
      chk("back_idle", {31'b0, icache_mem_req}, 32'd0);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic er, input logic [31:0] ei);
    fet_pc = pc; rdy = 1'b1; flush = 1'b0; mem_ready = 1'b0; #1;
    chk(tag, {31'b0, icache_ready}, {31'b0, er});
    if (er) chk({tag, "_inst"}, icache_inst, ei);
  endtask

  initial begin
    logic [31:0] pc;
    int dly, fl_at;
    for (int i = 0; i < 256; i++) begin mv[i] = 1'b0; ma[i] = 32'b0; md[i] = 16'b0; end
    rst_n = 1'b0; rdy = 1'b0; flush = 1'b0; fet_pc = 32'b0; mem_ready = 1'b0; mem_inst = 32'b0;
    #12;
    chk("rst_rdy", {31'b0, icache_ready}, 32'd0);
    chk("rst_inst", icache_inst, 32'd0);
    chk("rst_req", {31'b0, icache_mem_req}, 32'd0);
    chk("rst_addr", icache_mem_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Cold miss, then re-lookup hits
    fetch(32'h0, 32'h00500093, 3, -1);
    look("cold_rehit", 32'h0, 1'b1, 32'h00500093);
    // Compressed parcels
    fetch(32'h10, 32'h45050001, 1, -1);
    look("c_lo", 32'h10, 1'b1, 32'h00000001);
    look("c_hi", 32'h12, 1'b1, 32'h00004505);
    // Straddle: parcel 0x22 present with low bits 11, 0x24 absent
    fetch(32'h20, 32'h00130001, 0, -1);
    look("strad_miss", 32'h22, 1'b0, 32'h0);
    fetch(32'h22, 32'h00A00013, 2, -1);
    look("strad_hit", 32'h22, 1'b1, 32'h00A00013);
    // Wrap-around at the top of the array
    fetch(32'h1FE, 32'h12340013, 2, -1);
    look("wrap_hit", 32'h1FE, 1'b1, 32'h12340013);
    look("wrap_evict", 32'h0, 1'b0, 32'h0);
    fetch(32'h0, 32'h00500093, 1, -1);
    // Flush mid-miss, then flush coincident with mem_ready
    fetch(32'h40, 32'h00000513, 5, 2);
    look("flush_filled", 32'h40, 1'b1, 32'h00000513);
    fetch(32'h80, 32'h00000593, 2, 2);
    look("flush_same", 32'h80, 1'b1, 32'h00000593);

    // rdy low: no ready, no miss entry
    fet_pc = 32'h10; rdy = 1'b0; #1;
    chk("rdy0_hit", {31'b0, icache_ready}, 32'd0);
    fet_pc = 32'h300;
    @(posedge clk); #1;
    chk("rdy0_nomiss", {31'b0, icache_mem_req}, 32'd0);

    // Async reset in the middle of a miss
    fet_pc = 32'h100; rdy = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_req", {31'b0, icache_mem_req}, 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("rstmid_req0", {31'b0, icache_mem_req}, 32'd0);
    chk("rstmid_rdy0", {31'b0, icache_ready}, 32'd0);
    chk("rstmid_addr0", icache_mem_addr, 32'd0);
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    look("rstmid_lost", 32'h40, 1'b0, 32'h0);
    fetch(32'h40, 32'h00000513, 1, -1);

    // Random fetches over a range larger than the cache to force evictions
    for (int n = 0; n < 200; n++) begin
      pc = $urandom_range(0, 32'h5FF) & 32'hFFFF_FFFE;
      dly = $urandom_range(0, 3);
      fl_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dly) : -1;
      fetch(pc, {mem_hw(pc + 32'd2), mem_hw(pc)}, dly, fl_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
